// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared key width default and loader state encoding
package key_pkg;

    localparam int KEY_WIDTH_DEFAULT = 23;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        LOCKED,
        ERROR
    } state_t;

endpackage

// File: rtl/key_loader_if.sv
// rtl/key_loader_if.sv - serial key load handshake between key source and loader
interface key_loader_if;

    logic load_start;
    logic bit_in;
    logic bit_valid;
    logic bit_ready;

    modport master (
        output load_start,
        output bit_in,
        output bit_valid,
        input  bit_ready
    );

    modport slave (
        input  load_start,
        input  bit_in,
        input  bit_valid,
        output bit_ready
    );

endinterface

// File: rtl/key_idle_timer.sv
// rtl/key_idle_timer.sv - idle-cycle counter with synchronous clear and terminal flag
module key_idle_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic terminal
);

    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    // Flags the last tolerated idle cycle so the FSM leaves LOAD on that very edge.
    assign terminal = (count == W'(TIMEOUT - 1));

endmodule

// File: rtl/key_loader.sv
// rtl/key_loader.sv - serial key loader with even-parity check, idle timeout and retry lockout
module key_loader
    import key_pkg::*;
#(
    parameter int KEY_WIDTH = KEY_WIDTH_DEFAULT,
    parameter int TIMEOUT   = 16,
    parameter int MAX_RETRY = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    key_loader_if.slave          bus,
    output logic [KEY_WIDTH-1:0] key_out,
    output logic                 key_locked,
    output logic                 busy,
    output logic                 error,
    output logic                 lockout
);

    localparam int CW = $clog2(KEY_WIDTH + 1);
    localparam int FW = $clog2(MAX_RETRY + 1);

    state_t               state;
    state_t               state_next;
    logic [KEY_WIDTH-1:0] shift_reg;
    logic [CW-1:0]        bit_count;
    logic                 parity_acc;
    logic [FW-1:0]        fail_count;

    logic xfer;
    logic last_bit;
    logic start_load;
    logic fail;
    logic timer_done;

    assign xfer     = bus.bit_valid && (state == LOAD);
    assign last_bit = (bit_count == CW'(KEY_WIDTH));

    key_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (start_load || xfer),
        .inc      ((state == LOAD) && !xfer),
        .terminal (timer_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        bus.bit_ready = 1'b0;
        start_load    = 1'b0;
        fail          = 1'b0;
        case (state)
            IDLE: begin
                if (bus.load_start) begin
                    state_next = LOAD;
                    start_load = 1'b1;
                end
            end
            LOAD: begin
                bus.bit_ready = 1'b1;
                if (xfer && last_bit) begin
                    state_next = CHECK;
                end else if (!xfer && timer_done) begin
                    state_next = ERROR;
                    fail       = 1'b1;
                end
            end
            CHECK: begin
                if (parity_acc) begin
                    state_next = ERROR;
                    fail       = 1'b1;
                end else begin
                    state_next = LOCKED;
                end
            end
            LOCKED: begin
                state_next = LOCKED;
            end
            ERROR: begin
                if (bus.load_start && (fail_count != FW'(MAX_RETRY))) begin
                    state_next = LOAD;
                    start_load = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The parity bit lands only in the accumulator; the key bits also fill the shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg  <= '0;
            bit_count  <= '0;
            parity_acc <= 1'b0;
            fail_count <= '0;
            key_out    <= '0;
        end else begin
            if (start_load || fail) begin
                shift_reg  <= '0;
                bit_count  <= '0;
                parity_acc <= 1'b0;
            end else if (xfer) begin
                if (!last_bit) begin
                    shift_reg[bit_count] <= bus.bit_in;
                end
                parity_acc <= parity_acc ^ bus.bit_in;
                bit_count  <= bit_count + 1'b1;
            end
            if (fail) begin
                fail_count <= fail_count + 1'b1;
            end
            if ((state == CHECK) && (state_next == LOCKED)) begin
                key_out <= shift_reg;
            end
        end
    end

    assign key_locked = (state == LOCKED);
    assign busy       = (state == LOAD) || (state == CHECK);
    assign error      = (state == ERROR);
    assign lockout    = (fail_count == FW'(MAX_RETRY));

endmodule

// File: tb/tb_key_loader.sv
// tb/tb_key_loader.sv - directed self-checking bench for key_loader
module tb_key_loader;

    logic        clk;
    logic        rst;
    logic [22:0] key_out;
    logic        key_locked;
    logic        busy;
    logic        error;
    logic        lockout;

    int checks;
    int errors;

    key_loader_if bus_if();

    key_loader #(
        .KEY_WIDTH (23),
        .TIMEOUT   (16),
        .MAX_RETRY (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus_if),
        .key_out    (key_out),
        .key_locked (key_locked),
        .busy       (busy),
        .error      (error),
        .lockout    (lockout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic pulse_start();
        bus_if.load_start = 1'b1;
        step();
        bus_if.load_start = 1'b0;
    endtask

    task automatic send_bits(input logic [22:0] key, input int n);
        for (int i = 0; i < n; i++) begin
            bus_if.bit_valid = 1'b1;
            bus_if.bit_in    = key[i];
            step();
        end
        bus_if.bit_valid = 1'b0;
        bus_if.bit_in    = 1'b0;
    endtask

    task automatic send_key(input logic [22:0] key, input logic par);
        send_bits(key, 23);
        bus_if.bit_valid = 1'b1;
        bus_if.bit_in    = par;
        step();
        bus_if.bit_valid = 1'b0;
        bus_if.bit_in    = 1'b0;
    endtask

    task automatic hard_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic parity_fail_load(input string tag);
        pulse_start();
        send_key(23'h2AAAAA, 1'b0);
        check({tag, "_check_busy"}, 32'(busy), 32'd1);
        step();
        check({tag, "_error"}, 32'(error), 32'd1);
    endtask

    initial begin
        checks               = 0;
        errors               = 0;
        rst                  = 1'b1;
        bus_if.load_start    = 1'b0;
        bus_if.bit_in        = 1'b0;
        bus_if.bit_valid     = 1'b0;
        step();
        step();

        check("rst_key_out",    32'(key_out),          32'h0);
        check("rst_key_locked", 32'(key_locked),       32'd0);
        check("rst_busy",       32'(busy),             32'd0);
        check("rst_error",      32'(error),            32'd0);
        check("rst_lockout",    32'(lockout),          32'd0);
        check("rst_bit_ready",  32'(bus_if.bit_ready), 32'd0);
        rst = 1'b0;
        step();

        // Good load, odd-weight key with parity 1
        pulse_start();
        check("load_busy",      32'(busy),             32'd1);
        check("load_bit_ready", 32'(bus_if.bit_ready), 32'd1);
        send_key(23'h2AAAAA, 1'b1);
        check("chk_busy",       32'(busy),             32'd1);
        check("chk_bit_ready",  32'(bus_if.bit_ready), 32'd0);
        check("chk_key_locked", 32'(key_locked),       32'd0);
        check("chk_key_out",    32'(key_out),          32'h0);
        step();
        check("lock_key_locked", 32'(key_locked), 32'd1);
        check("lock_key_out",    32'(key_out),    32'h2AAAAA);
        check("lock_busy",       32'(busy),       32'd0);

        // LOCKED ignores load_start and bit_valid
        for (int i = 0; i < 30; i++) begin
            bus_if.bit_valid  = 1'b1;
            bus_if.bit_in     = 1'($urandom_range(0, 1));
            bus_if.load_start = (i == 3);
            step();
        end
        bus_if.bit_valid  = 1'b0;
        bus_if.load_start = 1'b0;
        check("hold_key_out",    32'(key_out),          32'h2AAAAA);
        check("hold_key_locked", 32'(key_locked),       32'd1);
        check("hold_bit_ready",  32'(bus_if.bit_ready), 32'd0);
        check("hold_busy",       32'(busy),             32'd0);

        // Asynchronous reset while LOCKED
        rst = 1'b1;
        #1;
        check("arst_lock_key_out",    32'(key_out),    32'h0);
        check("arst_lock_key_locked", 32'(key_locked), 32'd0);
        step();
        rst = 1'b0;
        step();

        // Parity failure then successful retry
        parity_fail_load("pf1");
        check("pf1_key_out",    32'(key_out),        32'h0);
        check("pf1_fail_count", 32'(dut.fail_count), 32'd1);
        check("pf1_lockout",    32'(lockout),        32'd0);
        pulse_start();
        check("retry_error", 32'(error), 32'd0);
        check("retry_busy",  32'(busy),  32'd1);
        send_key(23'h2AAAAA, 1'b1);
        step();
        check("retry_key_locked", 32'(key_locked), 32'd1);
        check("retry_key_out",    32'(key_out),    32'h2AAAAA);
        check("retry_error2",     32'(error),      32'd0);
        hard_reset();

        // Idle timeout: bits 0..5 then 16 idle cycles
        pulse_start();
        send_bits(23'h7FFFFF, 6);
        for (int i = 0; i < 15; i++) step();
        check("to_15_busy",      32'(busy),             32'd1);
        check("to_15_bit_ready", 32'(bus_if.bit_ready), 32'd1);
        check("to_15_error",     32'(error),            32'd0);
        step();
        check("to_16_error",     32'(error),            32'd1);
        check("to_16_bit_ready", 32'(bus_if.bit_ready), 32'd0);
        check("to_16_busy",      32'(busy),             32'd0);
        check("to_16_key_out",   32'(key_out),          32'h0);
        hard_reset();

        // Three parity failures reach lockout
        parity_fail_load("lk1");
        check("lk1_lockout", 32'(lockout), 32'd0);
        parity_fail_load("lk2");
        check("lk2_lockout", 32'(lockout), 32'd0);
        parity_fail_load("lk3");
        check("lk3_lockout",    32'(lockout),        32'd1);
        check("lk3_fail_count", 32'(dut.fail_count), 32'd3);
        pulse_start();
        send_bits(23'h7FFFFF, 4);
        check("lk4_error",     32'(error),            32'd1);
        check("lk4_busy",      32'(busy),             32'd0);
        check("lk4_bit_ready", 32'(bus_if.bit_ready), 32'd0);
        check("lk4_lockout",   32'(lockout),          32'd1);

        rst = 1'b1;
        #1;
        check("arst_lk_lockout", 32'(lockout), 32'd0);
        check("arst_lk_error",   32'(error),   32'd0);
        step();
        rst = 1'b0;
        step();

        // Reset after bit 10 of a load
        pulse_start();
        send_bits(23'h123456, 11);
        rst = 1'b1;
        #1;
        check("arst_mid_busy",       32'(busy),             32'd0);
        check("arst_mid_bit_ready",  32'(bus_if.bit_ready), 32'd0);
        check("arst_mid_key_out",    32'(key_out),          32'h0);
        check("arst_mid_fail_count", 32'(dut.fail_count),   32'd0);
        step();
        rst = 1'b0;
        step();

        pulse_start();
        send_key(23'h123456, 1'b1);
        step();
        check("reload_key_locked", 32'(key_locked), 32'd1);
        check("reload_key_out",    32'(key_out),    32'h123456);
        hard_reset();

        // All-ones key: 23 ones needs parity 1
        pulse_start();
        send_key(23'h7FFFFF, 1'b1);
        step();
        check("ones_key_locked", 32'(key_locked), 32'd1);
        check("ones_key_out",    32'(key_out),    32'h7FFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
